// File: rtl/hs_evt_queue_pkg.sv
// Shared types and default constants for the hs_syn event front end.
package hs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } hs_evt_state_t;

  localparam int HS_CNT_W     = 4;
  localparam int HS_BUSY_WAIT = 4;

endpackage

// File: rtl/hs_evt_queue_if.sv
// Event-queue signal bundle: the event source/consumer side is master, the queue is slave.
interface hs_evt_queue_if #(
  parameter int CNT_W = hs_pkg::HS_CNT_W
) ();

  logic             ev_in;
  logic             busy;
  logic             clr;
  logic             inA;
  logic [CNT_W-1:0] pending;
  logic             full;
  logic             ovf;
  logic             to_err;

  modport master (
    output ev_in, busy, clr,
    input  inA, pending, full, ovf, to_err
  );

  modport slave (
    input  ev_in, busy, clr,
    output inA, pending, full, ovf, to_err
  );

endinterface

// File: rtl/hs_evt_queue_cnt.sv
// Saturating up/down backlog counter; ovf_evt flags an increment refused at the ceiling.
module sat_updn_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         ovf_evt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] r_count;
  logic         r_full;
  logic [W-1:0] w_next;
  logic         w_ovf;

  // Next count: simultaneous inc/dec cancel, so an event arriving while full is kept when one issues
  always_comb begin
    w_next = r_count;
    w_ovf  = 1'b0;
    if (inc && !dec) begin
      if (r_full) begin
        w_ovf = 1'b1;
      end else begin
        w_next = r_count + W'(1);
      end
    end else if (dec && !inc && (r_count != {W{1'b0}})) begin
      w_next = r_count - W'(1);
    end else begin
      w_next = r_count;
    end
  end

  // Count and full flag registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {W{1'b0}};
      r_full  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_full  <= (w_next == CNT_MAX);
    end
  end

  assign count   = r_count;
  assign full    = r_full;
  assign ovf_evt = w_ovf;

endmodule

// File: rtl/hs_evt_queue.sv
// clkA-side event queue: buffers event pulses and replays them into hs_syn one crossing at a time.
module hs_evt_queue
  import hs_pkg::*;
#(
  parameter int CNT_W     = HS_CNT_W,
  parameter int BUSY_WAIT = HS_BUSY_WAIT
) (
  input  logic           clkA,
  input  logic           resetA,
  hs_evt_queue_if.slave  bus
);

  localparam int            WW       = $clog2(BUSY_WAIT);
  localparam logic [WW-1:0] WAIT_MAX = WW'(BUSY_WAIT - 1);

  hs_evt_state_t    r_state;
  hs_evt_state_t    w_state_nxt;
  logic [WW-1:0]    r_wcnt;
  logic [WW-1:0]    w_wcnt_nxt;
  logic             r_inA;
  logic             r_ovf;
  logic             r_to_err;
  logic             w_issue;
  logic             w_to_set;
  logic             w_ovf_evt;
  logic             w_full;
  logic [CNT_W-1:0] w_pending;

  sat_updn_cnt #(.W(CNT_W)) u_cnt (
    .clk     (clkA),
    .rst_n   (resetA),
    .inc     (bus.ev_in),
    .dec     (w_issue),
    .count   (w_pending),
    .full    (w_full),
    .ovf_evt (w_ovf_evt)
  );

  // Next-state logic; an event arriving this cycle can issue immediately from IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_issue     = 1'b0;
    w_to_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_wcnt_nxt = {WW{1'b0}};
        if (((w_pending != {CNT_W{1'b0}}) || bus.ev_in) && !bus.busy) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_BUSY: begin
        if (bus.busy) begin
          w_state_nxt = ST_WAIT_DONE;
          w_wcnt_nxt  = {WW{1'b0}};
        end else if (r_wcnt == WAIT_MAX) begin
          w_to_set    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_wcnt_nxt  = {WW{1'b0}};
        end else begin
          w_wcnt_nxt  = r_wcnt + WW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.busy) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wcnt_nxt  = {WW{1'b0}};
      end
    endcase
  end

  // State, request pulse and sticky flags; a set in the same cycle as clr wins
  always_ff @(posedge clkA or negedge resetA) begin
    if (!resetA) begin
      r_state  <= ST_IDLE;
      r_wcnt   <= {WW{1'b0}};
      r_inA    <= 1'b0;
      r_ovf    <= 1'b0;
      r_to_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_inA    <= w_issue;
      r_ovf    <= w_ovf_evt ? 1'b1 : (bus.clr ? 1'b0 : r_ovf);
      r_to_err <= w_to_set  ? 1'b1 : (bus.clr ? 1'b0 : r_to_err);
    end
  end

  assign bus.inA     = r_inA;
  assign bus.pending = w_pending;
  assign bus.full    = w_full;
  assign bus.ovf     = r_ovf;
  assign bus.to_err  = r_to_err;

endmodule

// File: doc/hs_evt_queue.md
# hs_evt_queue

- Source-domain (clkA) front end for the `hs_syn` handshake synchronizer.
- Accepts single-cycle event pulses at full clkA rate and holds them in a saturating backlog counter.
- Replays them into `hs_syn` one at a time, issuing a one-cycle `inA` pulse only while `busy` is low, so no event is lost while a crossing is in flight.
- Reports backlog depth, overflow and missing-acknowledge errors.

## Interface
Parameters:
- `CNT_W`, 4, backlog counter width; max backlog `2**CNT_W-1`.
- `BUSY_WAIT`, 4, clkA cycles allowed for `busy` to rise after an `inA` pulse (≥2).

Ports:
- `clkA` input 1: single clock (clkA domain of `hs_syn`).
- `resetA` input 1: asynchronous, active-low reset.
- `ev_in` input 1: event pulse; each high cycle is one event.
- `busy` input 1: from `hs_syn`; high while a crossing is outstanding.
- `clr` input 1: synchronous clear of sticky flags.
- `inA` output 1: request pulse to `hs_syn.inA`, exactly one cycle wide.
- `pending` output CNT_W: events accepted but not yet issued.
- `full` output 1: `pending == 2**CNT_W-1`.
- `ovf` output 1: sticky; an event was dropped.
- `to_err` output 1: sticky; `busy` failed to rise within `BUSY_WAIT` cycles.

## Operation
- Reset (async, `resetA` low): `inA`=0, `pending`=0, `full`=0, `ovf`=0, `to_err`=0, state IDLE, wait counter 0. Outputs clear immediately, not at the next edge.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if `(pending!=0 || ev_in) && !busy`, then `inA`<=1 and go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: `inA`<=0. Wait counter increments each cycle. If `busy`, go to WAIT_DONE. Else if counter reaches `BUSY_WAIT-1`, set `to_err` and go to IDLE. The event counts as delivered and is not retried.
  - WAIT_DONE: if `!busy`, go to IDLE.
- Backlog update at each edge: `pending` <= `pending + ev_in − issue`, where `issue` = IDLE-state request this edge.
  - Simultaneous `ev_in` and `issue`: `pending` unchanged. This holds even when full; that event is accepted.
  - `ev_in` while full and no `issue`: event dropped, `pending` stays at max, `ovf`<=1.
  - `pending` never wraps; underflow is impossible by construction.
- `clr`: clears `ovf`/`to_err` at the edge. If a set condition occurs in the same cycle, set wins.
- `ev_in` held high N cycles counts as N events.

## Timing
- Latency: `ev_in` sampled at edge k with empty backlog, IDLE and `busy` low → `inA` high for the cycle after edge k. Total latency is 1 cycle.
- `inA` is registered and is never high two consecutive cycles.
- Minimum request spacing: `inA` pulse, then ≥1 WAIT_BUSY cycle, the `busy` high period, then ≥1 IDLE edge after `busy` falls.
- `full` and `pending` are registered and update on the same edge.
- `busy` is already in the clkA domain (driven by `hs_syn` from clkA flops); no synchronizer here.
- Reset mid-handshake aborts the FSM to IDLE and discards the backlog. Recovering `hs_syn` is the system reset's responsibility.

## Structure
- Shared package `hs_pkg`:
  - FSM state enum `hs_evt_state_t`.
  - Default constants `HS_CNT_W`, `HS_BUSY_WAIT`.
- Single module. The saturating up/down counter is a natural sub-module `sat_updn_cnt` (inc, dec, count, full, ovf_evt). The FSM stays in `hs_evt_queue`.
- Integrate by wiring `inA`→`hs_syn.inA` and `hs_syn.busy`→`busy`.

## Test plan
- Single event: reset, one `ev_in` pulse with `busy` low → `inA` high exactly 1 cycle, 1 cycle later; `pending` stays 0.
- Burst under busy: hold `busy` high, send 5 pulses → `pending`=5. Then run 5 handshakes (`busy` high 6 cycles each, rising 2 cycles after `inA`) → exactly 5 `inA` pulses, `pending` steps 5→0.
- Overflow, CNT_W=3: `busy` high, 9 pulses → `pending`=7, `full`=1, `ovf`=1. Assert `clr` → `ovf`=0, `pending` still 7.
- Simultaneous: `pending`=7 (full), `busy` low, FSM IDLE, `ev_in` same cycle as issue → `pending` stays 7, `ovf` stays 0.
- Timeout, BUSY_WAIT=4: `busy` tied low, 1 event → `inA` pulse; `to_err`=1 after 4 cycles; the next event still issues.
- Async reset mid-operation: `pending`=3 in WAIT_DONE, pulse `resetA` low off-edge → all outputs 0 immediately; after release, one `ev_in` → normal 1-cycle `inA`.
- End-to-end with `hs_syn`, clkA 1 ns, clkB 3 ns: 20 back-to-back single-cycle `ev_in` pulses → exactly 20 `outB_pulse` on clkB, `ovf`=0 with CNT_W=5.
